// File: rtl/zeroriscy_fetch_pkg.sv
// ----------------------------------------------------------------------------
// zeroriscy_fetch_pkg
// Shared types and helpers for the parametrised instruction fetch FIFO.
//   fetch_entry_t   : one stored fetch word (address, data, bus-error flag)
//   FETCH_ADDR_INC  : byte distance between consecutive fetch words
//   is_compressed() : RV32C test on the low half of an instruction
//   next_word_addr(): word-aligned address of the following fetch word
// Optional feature macro used by the files importing this package:
//   ZR_FETCH_FIFO_ERR_EN (per-entry bus-error tracking)
// ----------------------------------------------------------------------------
package zeroriscy_fetch_pkg;

    localparam logic [31:0] FETCH_ADDR_INC = 32'h4;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] rdata;
        logic        err;
    } fetch_entry_t;

    // An instruction is 16-bit unless its two lowest bits are both set.
    function automatic logic is_compressed(input logic [15:0] half);
        return (half[1:0] != 2'b11);
    endfunction

    // Start of the next word; wraps naturally at 0xFFFF_FFFC -> 0.
    function automatic logic [31:0] next_word_addr(input logic [31:0] addr);
        return {addr[31:2], 2'b00} + FETCH_ADDR_INC;
    endfunction

endpackage

// File: rtl/zeroriscy_fetch_fifo_param_if.sv
// ----------------------------------------------------------------------------
// zeroriscy_fetch_fifo_param_if
// Bundles the fetch FIFO's memory-side input stream and IF-stage output
// stream. Signal names keep the FIFO's point of view (_i into the FIFO,
// _o out of it).
//   in_addr_i / in_rdata_i / in_valid_i : fetched word from the prefetcher
//   in_ready_o                          : FIFO can accept one more request
//   out_valid_o / out_ready_i           : instruction handshake to IF stage
//   out_rdata_o / out_addr_o            : realigned instruction and its PC
//   out_valid_stored_o                  : out_valid_o computed from flops only
//   in_err_i / out_err_o                : bus-error flags, present only when
//                                         ZR_FETCH_FIFO_ERR_EN is defined
// Modports: slave  = the FIFO itself
//           master = the environment driving/consuming the FIFO
// ----------------------------------------------------------------------------
interface zeroriscy_fetch_fifo_param_if;

    logic [31:0] in_addr_i;
    logic [31:0] in_rdata_i;
    logic        in_valid_i;
    logic        in_ready_o;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_rdata_o;
    logic [31:0] out_addr_o;
    logic        out_valid_stored_o;
`ifdef ZR_FETCH_FIFO_ERR_EN
    logic        in_err_i;
    logic        out_err_o;
`endif

    modport slave (
`ifdef ZR_FETCH_FIFO_ERR_EN
        input  in_err_i,
        output out_err_o,
`endif
        input  in_addr_i,
        input  in_rdata_i,
        input  in_valid_i,
        output in_ready_o,
        output out_valid_o,
        input  out_ready_i,
        output out_rdata_o,
        output out_addr_o,
        output out_valid_stored_o
    );

    modport master (
`ifdef ZR_FETCH_FIFO_ERR_EN
        output in_err_i,
        input  out_err_o,
`endif
        output in_addr_i,
        output in_rdata_i,
        output in_valid_i,
        input  in_ready_o,
        input  out_valid_o,
        output out_ready_i,
        input  out_rdata_o,
        input  out_addr_o,
        input  out_valid_stored_o
    );

endinterface

// File: rtl/zeroriscy_fetch_aligner.sv
// ----------------------------------------------------------------------------
// zeroriscy_fetch_aligner
// Combinational RV32C realignment of the instruction at the FIFO head.
//   word_i        : head fetch word
//   second_lo_i   : low half of the following fetch word
//   unaligned_i   : PC bit[1]; instruction starts in the upper half of word_i
//   rdata_o       : realigned instruction (16-bit instrs occupy [15:0])
//   compressed_o  : the instruction at the PC is 16-bit
//   needs_second_o: a 32-bit instruction straddles into the next word
// ----------------------------------------------------------------------------
module zeroriscy_fetch_aligner
    import zeroriscy_fetch_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [15:0] second_lo_i,
    input  logic        unaligned_i,
    output logic [31:0] rdata_o,
    output logic        compressed_o,
    output logic        needs_second_o
);

    assign rdata_o        = unaligned_i ? {second_lo_i, word_i[31:16]} : word_i;
    assign compressed_o   = unaligned_i ? is_compressed(word_i[31:16])
                                        : is_compressed(word_i[15:0]);
    assign needs_second_o = unaligned_i & ~compressed_o;

endmodule

// File: rtl/zeroriscy_fetch_fifo_param.sv
// ----------------------------------------------------------------------------
// zeroriscy_fetch_fifo_param
// Instruction fetch FIFO between the prefetch buffer and the IF stage.
// Holds DEPTH fetch words (entry 0 is the head), realigns 16/32-bit RV32C
// instructions across word boundaries and bypasses incoming data straight
// to the output when the FIFO is empty.
// Parameters:
//   DEPTH   : number of word entries (>= 3)
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear_i    : flush all entries for the next cycle
//   bus        : zeroriscy_fetch_fifo_param_if.slave (in/out streams)
//   count_o    : registered number of valid entries
// Optional feature: define ZR_FETCH_FIFO_ERR_EN to add per-entry bus-error
// flags (bus.in_err_i / bus.out_err_o). An errored head is presented
// immediately, without waiting for a second half.
// ----------------------------------------------------------------------------
module zeroriscy_fetch_fifo_param
    import zeroriscy_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 3
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear_i,
    zeroriscy_fetch_fifo_param_if.slave  bus,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned     CW        = $clog2(DEPTH + 1);
    // One slot stays free for the word of a request already in flight.
    localparam logic [CW-1:0]   READY_MAX = CW'(DEPTH - 2);

    fetch_entry_t     entry_q      [DEPTH];
    fetch_entry_t     entry_pushed [DEPTH];
    fetch_entry_t     entry_d      [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [DEPTH-1:0] valid_pushed;
    logic [DEPTH-1:0] valid_d;
    logic [DEPTH-1:0] write_en;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;

    logic             in_err;
    fetch_entry_t     in_entry;

    logic [31:0]      head_word;
    logic [31:0]      head_addr;
    logic [15:0]      second_lo;
    logic             head_avail;
    logic             second_avail;
    logic             head_err;
    logic             stored_err;

    logic [31:0]      aligned_rdata;
    logic             compressed;
    logic             needs_second;
    logic             stored_needs_second;

    logic             out_valid;
    logic             push;
    logic             pop;
    logic             pop_keep_head;

`ifdef ZR_FETCH_FIFO_ERR_EN
    logic             second_err;

    assign in_err     = bus.in_err_i;
    assign head_err   = valid_q[0] ? entry_q[0].err : bus.in_err_i;
    assign second_err = valid_q[1] ? entry_q[1].err : bus.in_err_i;
    assign stored_err = entry_q[0].err;
    // When the second half is needed but the head is clean, out_valid_o
    // already guarantees the second word is present, so second_err is real.
    assign bus.out_err_o = head_err | (needs_second & second_err);
`else
    assign in_err     = 1'b0;
    assign head_err   = 1'b0;
    assign stored_err = 1'b0;
`endif

    assign in_entry = '{addr: bus.in_addr_i, rdata: bus.in_rdata_i, err: in_err};

    // ------------------------------------------------------------------
    // Head view: stored entries take priority, otherwise the incoming word
    // ------------------------------------------------------------------
    assign head_word    = valid_q[0] ? entry_q[0].rdata : bus.in_rdata_i;
    assign head_addr    = valid_q[0] ? entry_q[0].addr  : bus.in_addr_i;
    assign second_lo    = valid_q[1] ? entry_q[1].rdata[15:0] : bus.in_rdata_i[15:0];
    assign head_avail   = valid_q[0] | bus.in_valid_i;
    assign second_avail = valid_q[1] | (valid_q[0] & bus.in_valid_i);

    zeroriscy_fetch_aligner u_aligner (
        .word_i         (head_word),
        .second_lo_i    (second_lo),
        .unaligned_i    (head_addr[1]),
        .rdata_o        (aligned_rdata),
        .compressed_o   (compressed),
        .needs_second_o (needs_second)
    );

    assign out_valid = (needs_second & ~head_err) ? second_avail : head_avail;

    // Flop-only variant: decode straight from the stored head entry.
    assign stored_needs_second = entry_q[0].addr[1] & ~is_compressed(entry_q[0].rdata[31:16]);

    assign bus.out_valid_o        = out_valid;
    assign bus.out_rdata_o        = aligned_rdata;
    assign bus.out_addr_o         = head_addr;
    assign bus.out_valid_stored_o = (stored_needs_second & ~stored_err) ? valid_q[1] : valid_q[0];
    assign bus.in_ready_o         = (count_q <= READY_MAX);
    assign count_o                = count_q;

    // ------------------------------------------------------------------
    // Push into the lowest free entry (valid flags are a thermometer)
    // ------------------------------------------------------------------
    assign push = bus.in_valid_i & ~clear_i & ~valid_q[DEPTH-1];
    assign pop  = out_valid & bus.out_ready_i & ~clear_i;

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_push
        if (gi == 0) begin : g_head
            assign write_en[gi] = push & ~valid_q[0];
        end else begin : g_tail
            assign write_en[gi] = push & ~valid_q[gi] & valid_q[gi-1];
        end
        assign entry_pushed[gi] = write_en[gi] ? in_entry : entry_q[gi];
        assign valid_pushed[gi] = valid_q[gi] | write_en[gi];
    end

    // A clean aligned compressed instruction only consumes the lower half
    // of the head word; everything else retires the head word.
    assign pop_keep_head = ~head_addr[1] & compressed & ~head_err;

    // ------------------------------------------------------------------
    // Pop applied on top of the merged push
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_d[i] = entry_pushed[i];
        end
        valid_d = valid_pushed;

        if (pop) begin
            if (pop_keep_head) begin
                entry_d[0].addr = {head_addr[31:2], 2'b10};
            end else begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    entry_d[i] = entry_pushed[i+1];
                    valid_d[i] = valid_pushed[i+1];
                end
                valid_d[DEPTH-1] = 1'b0;
                // Only the head address is tracked: recompute it rather than
                // trusting whatever address came with the shifted-in word.
                // A straddling 32-bit instr leaves the next one at +2.
                entry_d[0].addr = next_word_addr(head_addr)
                                | {30'd0, needs_second & ~head_err, 1'b0};
            end
        end

        if (clear_i) begin
            valid_d = '0;
        end
    end

    assign count_d = CW'($countones(valid_d));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            count_q <= count_d;
            for (int i = 0; i < DEPTH; i++) begin
                entry_q[i] <= entry_d[i];
            end
        end
    end

    // Pushing into a full FIFO loses data unless the FIFO is being flushed.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst_n)
        !(bus.in_valid_i && valid_q[DEPTH-1] && !clear_i));

    // Valid flags must remain contiguous from entry 0.
    a_valid_thermometer: assert property (@(posedge clk) disable iff (!rst_n)
        (((valid_q + 1'b1) & valid_q) == '0));

endmodule

// File: tb/tb_zeroriscy_fetch_fifo_param.sv
// ----------------------------------------------------------------------------
// tb_zeroriscy_fetch_fifo_param
// Directed bench for the fetch FIFO instantiated with DEPTH=4. Inputs are
// driven 2 time units after the rising edge; outputs are checked 1 unit
// later. The error-flag step exists only when ZR_FETCH_FIFO_ERR_EN is set.
// ----------------------------------------------------------------------------
module tb_zeroriscy_fetch_fifo_param;

    logic       clk;
    logic       rst_n;
    logic       clear_i;
    logic [2:0] count;
    int         tests    = 0;
    int         failures = 0;

    zeroriscy_fetch_fifo_param_if bus ();

    zeroriscy_fetch_fifo_param #(.DEPTH(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (clear_i),
        .bus     (bus),
        .count_o (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic v, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        bus.in_valid_i  = v;
        bus.in_addr_i   = a;
        bus.in_rdata_i  = d;
        bus.out_ready_i = rdy;
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        clear_i = 1'b0;
`ifdef ZR_FETCH_FIFO_ERR_EN
        bus.in_err_i = 1'b0;
`endif
        drive(1'b0, 32'h0, 32'h0, 1'b0);

        // Reset state
        check("rst_count",     32'(count), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready_o), 32'd1);
        check("rst_ovs",       32'(bus.out_valid_stored_o), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid_o), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;

        // Bypass of an aligned 32-bit word when empty
        drive(1'b1, 32'h100, 32'h0000_0013, 1'b1);
        check("byp_valid", 32'(bus.out_valid_o), 32'd1);
        check("byp_addr",  bus.out_addr_o, 32'h100);
        check("byp_rdata", bus.out_rdata_o, 32'h0000_0013);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("byp_count", 32'(count), 32'd0);
        check("byp_ovs",   32'(bus.out_valid_stored_o), 32'd0);
        check("byp_idle",  32'(bus.out_valid_o), 32'd0);

        // Two compressed instructions in one word
        drive(1'b1, 32'h200, 32'h0001_4501, 1'b1);
        check("c2_valid0", 32'(bus.out_valid_o), 32'd1);
        check("c2_addr0",  bus.out_addr_o, 32'h200);
        check("c2_rdata0", {16'h0, bus.out_rdata_o[15:0]}, 32'h4501);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("c2_count1", 32'(count), 32'd1);
        check("c2_valid1", 32'(bus.out_valid_o), 32'd1);
        check("c2_addr1",  bus.out_addr_o, 32'h202);
        check("c2_rdata1", {16'h0, bus.out_rdata_o[15:0]}, 32'h0001);
        check("c2_ovs1",   32'(bus.out_valid_stored_o), 32'd1);
        tick();
        check("c2_count2", 32'(count), 32'd0);

        // Branch target 0x302, 32-bit instruction straddling two words
        drive(1'b1, 32'h302, 32'hABCF_0000, 1'b1);
        check("ua_wait", 32'(bus.out_valid_o), 32'd0);
        tick();
        check("ua_count1", 32'(count), 32'd1);
        check("ua_ovs1",   32'(bus.out_valid_stored_o), 32'd0);
        drive(1'b1, 32'h304, 32'h1234_FFFF, 1'b1);
        check("ua_valid",  32'(bus.out_valid_o), 32'd1);
        check("ua_rdata",  bus.out_rdata_o, 32'hFFFF_ABCF);
        check("ua_addr",   bus.out_addr_o, 32'h302);
        check("ua_ovs2",   32'(bus.out_valid_stored_o), 32'd0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("ua_count2", 32'(count), 32'd1);
        check("ua_addr2",  bus.out_addr_o, 32'h306);
        check("ua_rdata2", {16'h0, bus.out_rdata_o[15:0]}, 32'h1234);
        check("ua_valid2", 32'(bus.out_valid_o), 32'd1);
        check("ua_ovs3",   32'(bus.out_valid_stored_o), 32'd1);
        tick();
        check("ua_count3", 32'(count), 32'd0);

        // Fill with out_ready_i low; watch in_ready_o
        drive(1'b1, 32'h400, 32'h0000_0013, 1'b0);
        tick();
        check("f_count1", 32'(count), 32'd1);
        check("f_ready1", 32'(bus.in_ready_o), 32'd1);
        check("f_addr1",  bus.out_addr_o, 32'h400);
        check("f_ovs1",   32'(bus.out_valid_stored_o), 32'd1);
        drive(1'b1, 32'h404, 32'h0010_0093, 1'b0);
        tick();
        check("f_count2", 32'(count), 32'd2);
        check("f_ready2", 32'(bus.in_ready_o), 32'd1);
        drive(1'b1, 32'h408, 32'h0020_0113, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("f_count3", 32'(count), 32'd3);
        check("f_ready3", 32'(bus.in_ready_o), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        check("f_pop_valid", 32'(bus.out_valid_o), 32'd1);
        check("f_pop_rdata", bus.out_rdata_o, 32'h0000_0013);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("f_count4", 32'(count), 32'd2);
        check("f_ready4", 32'(bus.in_ready_o), 32'd1);
        check("f_addr4",  bus.out_addr_o, 32'h404);
        check("f_rdata4", bus.out_rdata_o, 32'h0010_0093);

        // Fill completely, then flush with a simultaneous push
        drive(1'b1, 32'h40C, 32'h0030_0193, 1'b0);
        tick();
        drive(1'b1, 32'h410, 32'h0040_0213, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(bus.in_ready_o), 32'd0);
        clear_i = 1'b1;
        drive(1'b1, 32'h414, 32'h0050_0293, 1'b0);
        tick();
        clear_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("clr_count", 32'(count), 32'd0);
        check("clr_ovs",   32'(bus.out_valid_stored_o), 32'd0);
        check("clr_valid", 32'(bus.out_valid_o), 32'd0);

        // Address wrap: head at 0xFFFF_FFFC, stray address on second word
        drive(1'b1, 32'hFFFF_FFFC, 32'h0000_0013, 1'b0);
        tick();
        drive(1'b1, 32'hDEAD_BEEC, 32'h0010_0093, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("wr_count2", 32'(count), 32'd2);
        check("wr_addr0",  bus.out_addr_o, 32'hFFFF_FFFC);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("wr_count1", 32'(count), 32'd1);
        check("wr_addr1",  bus.out_addr_o, 32'h0000_0000);
        check("wr_rdata1", bus.out_rdata_o, 32'h0010_0093);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("wr_count0", 32'(count), 32'd0);

`ifdef ZR_FETCH_FIFO_ERR_EN
        // Clean bypass reports no error
        drive(1'b1, 32'h700, 32'h0000_0013, 1'b0);
        check("err_clean", 32'(bus.out_err_o), 32'd0);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        // Errored first half of an unaligned 32-bit instruction
        bus.in_err_i = 1'b1;
        drive(1'b1, 32'h602, 32'hABCF_0000, 1'b1);
        check("err_valid", 32'(bus.out_valid_o), 32'd1);
        check("err_flag",  32'(bus.out_err_o), 32'd1);
        tick();
        bus.in_err_i = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("err_count", 32'(count), 32'd0);
`endif

        // Asynchronous reset in the middle of operation
        drive(1'b1, 32'h800, 32'h0000_0013, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        check("ar_count_pre", 32'(count), 32'd1);
        rst_n = 1'b0;
        #1;
        check("ar_count", 32'(count), 32'd0);
        check("ar_ovs",   32'(bus.out_valid_stored_o), 32'd0);
        check("ar_ready", 32'(bus.in_ready_o), 32'd1);
        tick();
        rst_n = 1'b1;
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
